instr_fetch_unit: RTL and testbench

- Instruction-fetch front end that sits downstream of the program counter.
- Owns the sequential fetch address and issues word reads to instruction memory over a valid/ready request channel.
- Collects responses into a small FIFO and presents {pc, instruction} pairs to decode with a valid/ready handshake.
- Branch/jump redirects flush buffered instructions and discard stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: issues sequential word fetches to instruction
// memory, buffers returning words in a small FIFO tagged with their PC, and
// hands {pc, instruction} pairs to decode. A redirect flushes the buffer,
// restarts fetch at the target and discards responses already in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Architectural state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  // Buffer storage (no reset needed: validity is tracked by count_q)
  logic [31:0]   mem_pc_q   [FIFO_DEPTH];
  logic [31:0]   mem_data_q [FIFO_DEPTH];

  // Handshake / control terms
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic [31:0]   redirect_target;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // Credits cover both buffered and in-flight words so a response can never
  // find the buffer full. One extra bit keeps the sum from wrapping.
  assign credit_sum      = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit_ok       = credit_sum < (CW+1)'(FIFO_DEPTH);
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid  = rst_n && credit_ok && !redirect_valid;
  assign imem_req_addr   = fetch_pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;

  assign rsp_drop        = imem_rsp_valid && (drop_cnt_q != '0);
  assign push            = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

  assign inst_valid      = (count_q != '0) && !redirect_valid;
  assign inst_data       = mem_data_q[rd_ptr_q];
  assign inst_pc         = mem_pc_q[rd_ptr_q];
  assign pop             = inst_valid && inst_ready;

  // Next-state logic; redirect overrides every other update
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      // Everything still in flight is now stale; a response landing this
      // cycle is discarded directly, so it is not counted again.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Write kept responses into the buffer tagged with their PC
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
      mem_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // The credit rule must keep the buffer from ever being pushed while full
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(FIFO_DEPTH))));

  // Memory may only answer requests it has accepted
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding_q == '0)));

  // Stale responses are a subset of those in flight
  a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: one DUT with RESET_PC=0 and a
// second with RESET_PC=0xFFFF_FFF8 to observe address wrap-around.
module tb_instr_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_inst_valid;
  logic [31:0] w_inst_data, w_inst_pc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned lat    = 1;
  req_t        pend[$];
  logic        w_nx;
  logic [31:0] w_nx_addr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst_data(w_inst_data), .inst_pc(w_inst_pc)
  );

  // One clock cycle: record accepted requests, cross the edge, then present
  // memory responses (data = addr ^ K) for the new cycle at the falling edge.
  task automatic tick();
    req_t r;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
    end
    w_nx      = w_req_valid;
    w_nx_addr = w_req_addr;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      pend.delete();
      w_nx = 1'b0;
    end
    @(negedge clk);
    if (pend.size() != 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr ^ K;
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    w_rsp_valid = w_nx;
    w_rsp_data  = w_nx_addr ^ K;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({imem_req_valid, inst_valid, w_req_valid, w_inst_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got req/inst/wreq/winst=%b expected 0000",
               {imem_req_valid, inst_valid, w_req_valid, w_inst_valid});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL release_req: got valid=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
    end
    checks++;
    if ({w_req_valid, w_req_addr, w_inst_valid} !== {1'b1, 32'hFFFF_FFF8, 1'b0}) begin
      errors++;
      $display("FAIL release_req_w: got valid=%b addr=%h inst_valid=%b expected 1 fffffff8 0",
               w_req_valid, w_req_addr, w_inst_valid);
    end
  endtask

  // Continues directly from the release cycle of test_reset
  task automatic test_stream();
    logic [31:0] ea, ep;
    lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      ea = 32'(n) * 32'd4;
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, ea}) begin
        errors++;
        $display("FAIL stream_req c%0d: got valid=%b addr=%h expected 1 %h", n, imem_req_valid, imem_req_addr, ea);
      end
      if (n < 2) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency c%0d: got inst_valid=%b expected 0", n, inst_valid);
        end
      end else begin
        ep = 32'(n - 2) * 32'd4;
        checks++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, ep, ep ^ K}) begin
          errors++;
          $display("FAIL stream_inst c%0d: got v=%b pc=%h data=%h expected 1 %h %h",
                   n, inst_valid, inst_pc, inst_data, ep, ep ^ K);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea, ep;
    do_reset();
    lat = 1; inst_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      ea = 32'hFFFF_FFF8 + 32'(n) * 32'd4;
      checks++;
      if ({w_req_valid, w_req_addr} !== {1'b1, ea}) begin
        errors++;
        $display("FAIL wrap_req c%0d: got valid=%b addr=%h expected 1 %h", n, w_req_valid, w_req_addr, ea);
      end
      if (n >= 2) begin
        ep = 32'hFFFF_FFF8 + 32'(n - 2) * 32'd4;
        checks++;
        if ({w_inst_valid, w_inst_pc, w_inst_data} !== {1'b1, ep, ep ^ K}) begin
          errors++;
          $display("FAIL wrap_inst c%0d: got v=%b pc=%h data=%h expected 1 %h %h",
                   n, w_inst_valid, w_inst_pc, w_inst_data, ep, ep ^ K);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ep;
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      checks++;
      if (imem_req_valid !== (n < 4) || (n < 4 && imem_req_addr !== 32'(n) * 32'd4)) begin
        errors++;
        $display("FAIL bp_req c%0d: got valid=%b addr=%h expected valid=%b addr=%h",
                 n, imem_req_valid, imem_req_addr, (n < 4), 32'(n) * 32'd4);
      end
      checks++;
      if (inst_valid !== (n >= 2) || (n >= 2 && {inst_pc, inst_data} !== {32'h0, K})) begin
        errors++;
        $display("FAIL bp_hold c%0d: got v=%b pc=%h data=%h expected v=%b pc=00000000 data=%h",
                 n, inst_valid, inst_pc, inst_data, (n >= 2), K);
      end
      tick();
    end
    inst_ready = 1'b1;
    for (int n = 10; n < 14; n++) begin
      #1;
      ep = 32'(n - 10) * 32'd4;
      checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, ep, ep ^ K}) begin
        errors++;
        $display("FAIL bp_drain c%0d: got v=%b pc=%h data=%h expected 1 %h %h",
                 n, inst_valid, inst_pc, inst_data, ep, ep ^ K);
      end
      if (n == 10) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_req: got valid=%b expected 0", imem_req_valid);
        end
      end
      if (n == 11 || n == 12) begin
        ep = 32'h10 + 32'(n - 11) * 32'd4;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, ep}) begin
          errors++;
          $display("FAIL bp_resume c%0d: got valid=%b addr=%h expected 1 %h", n, imem_req_valid, imem_req_addr, ep);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL rd_held: got valid=%b addr=%h expected 1 00000008", imem_req_valid, imem_req_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    checks++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_withdraw: got req=%b inst=%b expected 0 0", imem_req_valid, inst_valid);
    end
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL rd_target: got valid=%b addr=%h expected 1 00000100", imem_req_valid, imem_req_addr);
    end
    for (int n = 3; n < 7; n++) begin
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_stale c%0d: got inst_valid=%b pc=%h expected 0", n, inst_valid, inst_pc);
      end
      tick();
    end
    for (int n = 7; n < 9; n++) begin
      #1;
      checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h100 + 32'(n - 7) * 32'd4, (32'h100 + 32'(n - 7) * 32'd4) ^ K}) begin
        errors++;
        $display("FAIL rd_first c%0d: got v=%b pc=%h data=%h expected pc=%h",
                 n, inst_valid, inst_pc, inst_data, 32'h100 + 32'(n - 7) * 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({inst_valid, inst_pc, inst_data, imem_rsp_valid} !== {1'b1, 32'h0, K, 1'b1}) begin
      errors++;
      $display("FAIL rr_setup: got v=%b pc=%h data=%h rsp=%b expected 1 00000000 %h 1",
               inst_valid, inst_pc, inst_data, imem_rsp_valid, K);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    checks++;
    if ({inst_valid, imem_req_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rr_gate: got inst=%b req=%b expected 0 0", inst_valid, imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rr_flush: got inst=%b req=%b addr=%h expected 0 1 00000200",
               inst_valid, imem_req_valid, imem_req_addr);
    end
    tick();
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_empty: got inst_valid=%b pc=%h expected 0", inst_valid, inst_pc);
    end
    tick();
    #1;
    checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h200, 32'h200 ^ K}) begin
      errors++;
      $display("FAIL rr_restart: got v=%b pc=%h data=%h expected 1 00000200 %h",
               inst_valid, inst_pc, inst_data, 32'h200 ^ K);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gate: got req=%b expected 0", imem_req_valid);
    end
    tick();
    redirect_pc = 32'h0000_0404;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h404, 1'b0}) begin
      errors++;
      $display("FAIL b2b_last_wins: got req=%b addr=%h inst=%b expected 1 00000404 0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
    tick();
    tick();
    #1;
    checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h404, 32'h404 ^ K}) begin
      errors++;
      $display("FAIL b2b_inst: got v=%b pc=%h data=%h expected 1 00000404 %h",
               inst_valid, inst_pc, inst_data, 32'h404 ^ K);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    #1;
    checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, K}) begin
      errors++;
      $display("FAIL rm_setup: got v=%b pc=%h data=%h expected 1 00000000 %h", inst_valid, inst_pc, inst_data, K);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_req_in_reset: got req=%b expected 0", imem_req_valid);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rm_after: got inst=%b req=%b addr=%h expected 0 1 00000000",
               inst_valid, imem_req_valid, imem_req_addr);
    end
    tick();
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_empty: got inst_valid=%b pc=%h expected 0", inst_valid, inst_pc);
    end
    tick();
    #1;
    checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, K}) begin
      errors++;
      $display("FAIL rm_refetch: got v=%b pc=%h data=%h expected 1 00000000 %h", inst_valid, inst_pc, inst_data, K);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;
    w_nx = 1'b0; w_nx_addr = '0;
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_redirect_drop();
    test_redirect_with_rsp();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
